// File: rtl/bcd_cascade_counter_pkg.sv
// Shared definitions for the cascaded BCD event counter: digit width,
// terminal digit value, snapshot FSM states and the per-digit increment.
package bcd_cascade_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  // Any value at or above 9 rolls to 0, so a corrupted digit self-recovers.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    if (d >= BCD_MAX) r = '0;
    else              r = d + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_cascade_counter_digit.sv
// One decade of the cascade: a 0..9 register that advances on inc and
// can be told to stick at 9 when the whole counter saturates.
module bcd_digit
  import bcd_cascade_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             hold_max,
  output logic [BCD_W-1:0] digit,
  output logic             is_max
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc && !(hold_max && (digit_q == BCD_MAX))) begin
      digit_d = bcd_inc(digit_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign is_max = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD event counter with wrap/saturate terminal behaviour and a
// valid/ready snapshot port that freezes a coherent copy of the count.
module bcd_cascade_counter
  import bcd_cascade_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_in,
  input  logic                      clear,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      carry_out,
  output logic                      sat,
  input  logic                      snap_req,
  output logic                      snap_valid,
  input  logic                      snap_ready,
  output logic [BCD_W*DIGITS-1:0]   snap_data
);

  localparam bit SATURATE = (WRAP == 0);

  logic [DIGITS-1:0] inc_en;
  logic [DIGITS-1:0] is_max;
  logic              all_max;
  logic              term_tick;
  logic              hold_max;

  logic carry_q, carry_d;
  logic sat_q, sat_d;

  snap_state_e                 state_q;
  logic                        snap_valid_q;
  logic [BCD_W*DIGITS-1:0]     snap_data_q;

  // Digit k advances only when every lower digit is at 9 on a tick.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign inc_en[g] = tick_in;
    end else begin : g_upper
      assign inc_en[g] = tick_in & (&is_max[g-1:0]);
    end

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .inc      (inc_en[g]),
      .hold_max (hold_max),
      .digit    (count[g*BCD_W +: BCD_W]),
      .is_max   (is_max[g])
    );
  end

  assign all_max   = &is_max;
  assign term_tick = tick_in & all_max;
  assign hold_max  = SATURATE & all_max;

  always_comb begin
    carry_d = 1'b0;
    sat_d   = sat_q;
    if (clear) begin
      sat_d = 1'b0;
    end else if (term_tick) begin
      carry_d = !SATURATE;
      sat_d   = sat_q | SATURATE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      sat_q   <= sat_d;
    end
  end

  // Snapshot capture uses the registered count, i.e. the value before this
  // cycle's tick lands; requests while holding are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snap_req) begin
            snap_data_q  <= count;
            snap_valid_q <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (snap_valid_q && snap_ready) begin
            snap_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          snap_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign carry_out  = carry_q;
  assign sat        = sat_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed bench for bcd_cascade_counter: three instances cover 4-digit wrap,
// 2-digit wrap and 2-digit saturate; the snapshot port is driven from a table.
module tb_bcd_cascade_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_tick = 0, a_clear = 0, a_req = 0, a_rdy = 0;
  logic [15:0] a_count, a_snap;
  logic        a_carry, a_sat, a_valid;

  logic        b_tick = 0, b_clear = 0, b_req = 0, b_rdy = 0;
  logic [7:0]  b_count, b_snap;
  logic        b_carry, b_sat, b_valid;

  logic        c_tick = 0, c_clear = 0, c_req = 0, c_rdy = 0;
  logic [7:0]  c_count, c_snap;
  logic        c_carry, c_sat, c_valid;

  bcd_cascade_counter #(.DIGITS(4), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .tick_in(a_tick), .clear(a_clear), .count(a_count),
    .carry_out(a_carry), .sat(a_sat), .snap_req(a_req), .snap_valid(a_valid),
    .snap_ready(a_rdy), .snap_data(a_snap));

  bcd_cascade_counter #(.DIGITS(2), .WRAP(1)) u_b (
    .clk(clk), .rst(rst), .tick_in(b_tick), .clear(b_clear), .count(b_count),
    .carry_out(b_carry), .sat(b_sat), .snap_req(b_req), .snap_valid(b_valid),
    .snap_ready(b_rdy), .snap_data(b_snap));

  bcd_cascade_counter #(.DIGITS(2), .WRAP(0)) u_c (
    .clk(clk), .rst(rst), .tick_in(c_tick), .clear(c_clear), .count(c_count),
    .carry_out(c_carry), .sat(c_sat), .snap_req(c_req), .snap_valid(c_valid),
    .snap_ready(c_rdy), .snap_data(c_snap));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        tick;
    logic        clr;
    logic        req;
    logic        rdy;
    logic [15:0] exp_count;
    logic        exp_valid;
    logic        chk_snap;
    logic [15:0] exp_snap;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0043, 1'b1, 1'b1, 16'h0042};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, bcd4(43 + i), 1'b1, 1'b1, 16'h0042};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0048, 1'b1, 1'b1, 16'h0042};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0048, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0048, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0049, 1'b1, 1'b1, 16'h0048};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0048};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h0048};

    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_a_count", 32'(a_count), 32'h0);
    chk("reset_a_carry", 32'(a_carry), 32'h0);
    chk("reset_a_valid", 32'(a_valid), 32'h0);
    chk("reset_a_snap",  32'(a_snap),  32'h0);
    chk("reset_c_sat",   32'(c_sat),   32'h0);

    a_tick = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("single_count", 32'(a_count), 32'(bcd4(i)));
      chk("single_carry", 32'(a_carry), 32'h0);
    end
    a_tick = 1'b0;

    for (int i = 1; i <= 105; i++) begin
      b_tick = (i <= 100);
      c_tick = 1'b1;
      cyc();
      chk("wrap_count", 32'(b_count), (i < 100) ? 32'(bcd4(i)) : 32'h0);
      chk("wrap_carry", 32'(b_carry), (i == 100) ? 32'h1 : 32'h0);
      chk("sat_count",  32'(c_count), 32'(bcd4((i < 99) ? i : 99)));
      chk("sat_flag",   32'(c_sat),   (i >= 100) ? 32'h1 : 32'h0);
      chk("sat_carry",  32'(c_carry), 32'h0);
    end
    b_tick = 1'b0;

    c_clear = 1'b1;
    cyc();
    c_clear = 1'b0;
    chk("clear_tick_count", 32'(c_count), 32'h0);
    chk("clear_tick_sat",   32'(c_sat),   32'h0);

    a_clear = 1'b1;
    cyc();
    a_clear = 1'b0;
    chk("a_clear_count", 32'(a_count), 32'h0);
    a_tick = 1'b1;
    for (int i = 1; i <= 42; i++) cyc();
    a_tick = 1'b0;
    chk("a_preload_42", 32'(a_count), 32'h0042);

    for (int i = 1; i <= 100; i++) cyc();
    c_tick = 1'b0;
    chk("resat_count", 32'(c_count), 32'h99);
    chk("resat_flag",  32'(c_sat),   32'h1);

    for (int v = 0; v < 12; v++) begin
      a_tick  = vecs[v].tick;
      a_clear = vecs[v].clr;
      a_req   = vecs[v].req;
      a_rdy   = vecs[v].rdy;
      cyc();
      chk($sformatf("snap_vec%0d_count", v), 32'(a_count), 32'(vecs[v].exp_count));
      chk($sformatf("snap_vec%0d_valid", v), 32'(a_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("snap_vec%0d_carry", v), 32'(a_carry), 32'h0);
      if (vecs[v].chk_snap)
        chk($sformatf("snap_vec%0d_data", v), 32'(a_snap), 32'(vecs[v].exp_snap));
    end

    rst    = 1'b1;
    a_tick = 1'b1;
    a_req  = 1'b0;
    a_clear = 1'b0;
    cyc();
    rst    = 1'b0;
    a_tick = 1'b0;
    chk("rst_hold_valid", 32'(a_valid), 32'h0);
    chk("rst_hold_count", 32'(a_count), 32'h0);
    chk("rst_hold_snap",  32'(a_snap),  32'h0);
    chk("rst_c_sat",      32'(c_sat),   32'h0);
    chk("rst_c_count",    32'(c_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
